// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Turns a symbolic operation (ALU op code plus two register addresses) into
//   the 16-bit type-0 instruction word that the instruction decoder expects.
//   Encoded words are queued in a small FIFO and handed to the decoder one per
//   valid/ready handshake. Op codes the decoder cannot decode are accepted but
//   dropped, and each one is reported with a one-cycle pulse and a saturating
//   counter.
//
// Instruction word layout:
//   [15]    0 (type-0 instruction)
//   [14:6]  9-bit opcode
//   [5:3]   addr1
//   [2:0]   addr2
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     source presents an operation this cycle
//   in_ready     encoder can accept an operation (FIFO not full)
//   alu_op       requested ALU op code
//   addr1        first register address
//   addr2        second register address
//   flush        synchronous clear of all queued instructions
//   instr        encoded instruction at the FIFO head (zero when empty)
//   instr_valid  instr holds a queued instruction
//   instr_ready  consumer takes instr this cycle
//   count        number of queued entries, 0..DEPTH
//   illegal      one-cycle pulse the cycle after an illegal op is accepted
//   illegal_cnt  saturating count of illegal ops accepted
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    alu_op,
  input  logic [2:0]    addr1,
  input  logic [2:0]    addr2,
  input  logic          flush,
  output logic [15:0]   instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW:0]   count,
  output logic          illegal,
  output logic [7:0]    illegal_cnt
);

  // ALU op codes the decoder understands. Everything else is illegal.
  typedef enum logic [4:0] {
    OP_ADD   = 5'd1,
    OP_AND   = 5'd2,
    OP_SUB   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_MOV   = 5'd6,
    OP_ADC   = 5'd7,
    OP_NOT   = 5'd8,
    OP_SAR   = 5'd9,
    OP_SLR   = 5'd10,
    OP_SAL   = 5'd11,
    OP_SLL   = 5'd12,
    OP_ROL   = 5'd13,
    OP_ROR   = 5'd14,
    OP_SHOWR = 5'd31
  } aluOp_e;

  // ShowR does not follow the zero-extended pattern of the ALU ops.
  localparam logic [8:0]  SHOWR_OPCODE = 9'b000_010_010;
  localparam logic [AW:0] FULL_COUNT   = DEPTH[AW:0];

  // FIFO storage and bookkeeping
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          illegal_q, illegal_d;
  logic [7:0]    illegalCnt_q, illegalCnt_d;

  // Decode / handshake signals
  logic          opLegal;
  logic [8:0]    opcode;
  logic [15:0]   encodedWord;
  logic          accept;
  logic          push;
  logic          pop;

  // Map the requested op to its 9-bit opcode and flag whether the decoder
  // can handle it at all.
  always_comb begin
    opLegal = 1'b0;
    opcode  = 9'd0;
    case (alu_op)
      OP_ADD, OP_AND, OP_SUB, OP_OR, OP_XOR, OP_MOV, OP_ADC,
      OP_NOT, OP_SAR, OP_SLR, OP_SAL, OP_SLL, OP_ROL, OP_ROR: begin
        opLegal = 1'b1;
        opcode  = {4'b0000, alu_op};
      end
      OP_SHOWR: begin
        opLegal = 1'b1;
        opcode  = SHOWR_OPCODE;
      end
      default: begin
        opLegal = 1'b0;
        opcode  = 9'd0;
      end
    endcase
  end

  assign encodedWord = {1'b0, opcode, addr1, addr2};

  // in_ready comes only from the registered count, so a pop in the same cycle
  // never opens a slot for a full FIFO.
  assign in_ready    = (count_q != FULL_COUNT);
  assign instr_valid = (count_q != '0);
  assign accept      = in_valid && in_ready;

  // flush wins over both sides of the FIFO: nothing is written and nothing is
  // considered consumed, because the whole queue is being discarded anyway.
  assign push = accept && opLegal && !flush;
  assign pop  = instr_valid && instr_ready && !flush;

  // Next-state for pointers and occupancy. Pointer width equals log2(DEPTH),
  // so the increment wraps naturally.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Illegal ops still complete their handshake (even during flush) so they
  // are always reported; the counter sticks at its maximum.
  always_comb begin
    illegal_d    = accept && !opLegal;
    illegalCnt_d = illegalCnt_q;
    if (illegal_d && (illegalCnt_q != 8'hFF)) begin
      illegalCnt_d = illegalCnt_q + 8'd1;
    end
  end

  // Control registers: pointers, count and illegal-op reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      illegal_q    <= 1'b0;
      illegalCnt_q <= 8'd0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      illegal_q    <= illegal_d;
      illegalCnt_q <= illegalCnt_d;
    end
  end

  // FIFO storage: only legal, non-flushed accepts write an entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (push) begin
      mem_q[wrPtr_q] <= encodedWord;
    end
  end

  // Output is read from registered state only, so a new op is visible no
  // earlier than the cycle after it is accepted.
  assign instr       = instr_valid ? mem_q[rdPtr_q] : 16'h0000;
  assign count       = count_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = illegalCnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Purpose:
//   Self-checking bench for instr_encoder. The driver issues operations and
//   pushes the expected encoded word into a scoreboard queue; an independent
//   monitor compares DUT outputs against the scoreboard each cycle and pops
//   an entry whenever the DUT hands an instruction over.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    alu_op;
  logic [2:0]    addr1;
  logic [2:0]    addr2;
  logic          flush;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW:0]   count;
  logic          illegal;
  logic [7:0]    illegal_cnt;

  int errorCount = 0;
  int checkCount = 0;

  // Reference model state
  logic [15:0] expQ[$];
  bit          pendingPush    = 1'b0;
  bit          pendingIllegal = 1'b0;
  bit          expIllegalNow  = 1'b0;
  int          expIllegalCnt  = 0;

  instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .addr1       (addr1),
    .addr2       (addr2),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .count       (count),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Decodable ops: 1..14 and ShowR (31)
  function automatic bit isLegal(int op);
    return ((op >= 1) && (op <= 14)) || (op == 31);
  endfunction

  // Instruction word from the encoding rules: opcode*64 + addr1*8 + addr2
  function automatic logic [15:0] encodeWord(int op, int a1, int a2);
    int opc;
    opc = (op == 31) ? 18 : op;
    return 16'(opc * 64 + a1 * 8 + a2);
  endfunction

  // One comparison; reports a FAIL line on mismatch
  task automatic checkOutput(string name, logic [15:0] actual, logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and record in the
  // scoreboard what the encoder should do with them at the next edge.
  task automatic applyStimulus(bit v, int op, int a1, int a2, bit rdy, bit fl);
    @(posedge clk);
    #1;
    pendingPush    = 1'b0;
    pendingIllegal = 1'b0;
    in_valid       = v;
    alu_op         = 5'(op);
    addr1          = 3'(a1);
    addr2          = 3'(a2);
    instr_ready    = rdy;
    flush          = fl;
    if (v && (expQ.size() != DEPTH)) begin
      if (!isLegal(op)) begin
        pendingIllegal = 1'b1;
      end else if (!fl) begin
        expQ.push_back(encodeWord(op, a1, a2));
        pendingPush = 1'b1;
      end
    end
  endtask

  task automatic idle(bit rdy, int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, 0, 0, 0, rdy, 1'b0);
    end
  endtask

  // Monitor: on the falling edge compare DUT outputs with the model state,
  // pop the scoreboard on a handshake, then advance the illegal-op model.
  always @(negedge clk) begin
    if (rst_n) begin
      int expCount;
      expCount = expQ.size() - int'(pendingPush);
      checkOutput("count", 16'(count), 16'(expCount));
      checkOutput("instr_valid", 16'(instr_valid), 16'(expCount != 0));
      checkOutput("in_ready", 16'(in_ready), 16'(expCount != DEPTH));
      if (expCount == 0) begin
        checkOutput("instr_empty", instr, 16'h0000);
      end
      checkOutput("illegal", 16'(illegal), 16'(expIllegalNow));
      checkOutput("illegal_cnt", 16'(illegal_cnt), 16'(expIllegalCnt));
      if (instr_valid && instr_ready) begin
        if (expCount == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpected_pop: got %h expected none at %0t", instr, $time);
        end else begin
          checkOutput("instr_word", instr, expQ[0]);
          void'(expQ.pop_front());
        end
      end
      if (flush) begin
        expQ.delete();
      end
      expIllegalNow = pendingIllegal;
      if (pendingIllegal && (expIllegalCnt < 255)) begin
        expIllegalCnt++;
      end
    end
  end

  // Asynchronous reset with an immediate check of the reset values
  task automatic assertReset();
    @(posedge clk);
    #1;
    in_valid       = 1'b0;
    instr_ready    = 1'b0;
    flush          = 1'b0;
    pendingPush    = 1'b0;
    pendingIllegal = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_count", 16'(count), 16'h0000);
    checkOutput("rst_instr_valid", 16'(instr_valid), 16'h0000);
    checkOutput("rst_instr", instr, 16'h0000);
    checkOutput("rst_illegal", 16'(illegal), 16'h0000);
    checkOutput("rst_illegal_cnt", 16'(illegal_cnt), 16'h0000);
    expQ.delete();
    expIllegalNow = 1'b0;
    expIllegalCnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    in_valid    = 1'b0;
    alu_op      = 5'd0;
    addr1       = 3'd0;
    addr2       = 3'd0;
    instr_ready = 1'b0;
    flush       = 1'b0;
    rst_n       = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("init_count", 16'(count), 16'h0000);
    checkOutput("init_instr_valid", 16'(instr_valid), 16'h0000);
    checkOutput("init_instr", instr, 16'h0000);
    checkOutput("init_illegal_cnt", 16'(illegal_cnt), 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single encode, then pop it
    applyStimulus(1'b1, 1, 3, 5, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // ShowR encode
    applyStimulus(1'b1, 31, 2, 0, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // Fill, reject while full (also with a pop in the same cycle), drain
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, i, 0, 0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 5, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6, 1, 1, 1'b1, 1'b0);
    idle(1'b1, 5);

    // Concurrent push/pop streaming through pointer wrap
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, (i % 14) + 1, i % 8, (i * 3) % 8, 1'b1, 1'b0);
    end
    idle(1'b1, 3);

    // Illegal ops 0 and 20
    applyStimulus(1'b1, 0, 1, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 20, 3, 4, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Randomized mix with occasional flush
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    idle(1'b1, 5);

    // Flush with a legal accept in the same cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, i + 7, i, 7 - i, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 12, 5, 5, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Saturation of the illegal counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 15 + (i % 16), i % 8, 0, 1'b1, 1'b0);
    end
    idle(1'b1, 2);
    checkOutput("illegal_cnt_sat", 16'(illegal_cnt), 16'd255);

    // Reset asserted with entries queued
    applyStimulus(1'b1, 2, 1, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3, 2, 2, 1'b0, 1'b0);
    assertReset();
    idle(1'b0, 1);

    // Encoder works again after reset
    applyStimulus(1'b1, 14, 7, 7, 1'b0, 1'b0);
    idle(1'b1, 3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
